// File: rtl/gb_pkg.sv
// Shared Game Boy bus constants and the OAM DMA state encoding.
// The source-page helper folds the echo-RAM range E0-FF back onto C0-DF.
package gb_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int unsigned OAM_LEN      = 160;
    localparam logic [15:0] HI_PAGE      = 16'hFF00;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        XFER,
        DRAIN
    } dma_state_t;

    function automatic logic [7:0] src_page(input logic [7:0] raw);
        return (raw >= 8'hE0) ? (raw & 8'hDF) : raw;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies XFER_LEN bytes from {page,00} into OAM and arbitrates
// the main bus between the CPU and the transfer; FF00-FFFF always stays with the CPU.
module oam_dma
    import gb_pkg::*;
#(
    parameter int unsigned XFER_LEN = OAM_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    output logic [7:0]  cpu_d_in,
    output logic [15:0] bus_addr,
    output logic        bus_write,
    output logic [7:0]  bus_d_wr,
    input  logic [7:0]  bus_d_rd,
    input  logic [7:0]  hi_d_rd,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_d_wr,
    output logic        oam_write,
    output logic        dma_active
);

    localparam logic [7:0] LAST_INDEX = 8'(XFER_LEN - 1);

    dma_state_t state;
    dma_state_t state_next;
    logic [7:0] index;
    logic [7:0] index_next;
    logic [7:0] src_raw;
    logic [7:0] src_hi;
    logic       start;
    logic       cpu_hi;
    logic       cpu_locked;

    assign start      = cpu_write && (cpu_addr == DMA_REG_ADDR);
    assign cpu_hi     = (cpu_addr >= HI_PAGE);
    assign src_hi     = src_page(src_raw);
    assign dma_active = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        bus_addr   = cpu_addr;
        bus_d_wr   = cpu_d_out;
        bus_write  = cpu_write && !cpu_hi;
        cpu_locked = 1'b0;

        case (state)
            IDLE: begin
            end
            DELAY: begin
                state_next = XFER;
            end
            XFER: begin
                bus_addr   = {src_hi, index};
                bus_write  = 1'b0;
                cpu_locked = 1'b1;
                if (index == LAST_INDEX) begin
                    state_next = DRAIN;
                end else begin
                    index_next = index + 8'd1;
                end
            end
            DRAIN: begin
                bus_write  = 1'b0;
                cpu_locked = 1'b1;
                state_next = IDLE;
            end
        endcase

        // A new FF46 write wins over whatever the transfer would do next.
        if (start) begin
            state_next = DELAY;
            index_next = '0;
        end

        if (cpu_addr == DMA_REG_ADDR) begin
            cpu_d_in = src_raw;
        end else if (cpu_hi) begin
            cpu_d_in = hi_d_rd;
        end else if (cpu_locked) begin
            cpu_d_in = 8'hFF;
        end else begin
            cpu_d_in = bus_d_rd;
        end
    end

    // The byte read in an XFER cycle lands in OAM on the following cycle,
    // including the read made in the cycle a restart is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_raw   <= 8'hFF;
            oam_write <= 1'b0;
            oam_addr  <= '0;
            oam_d_wr  <= '0;
        end else begin
            if (start) begin
                src_raw <= cpu_d_out;
            end
            oam_write <= (state == XFER);
            if (state == XFER) begin
                oam_addr <= index;
                oam_d_wr <= bus_d_rd;
            end
        end
    end

endmodule
